round_timer: RTL and testbench

- Consumes the free-running 20-bit tenths-of-second count from system_clock, which runs at 10 Hz from the 50 MHz clock.
- Turns that count into a per-round countdown for gameplay: start, pause, bonus-time add and expiry.
- Outputs BCD digits for the score/HUD renderer and a one-cycle time_up pulse for the game-state controller.

---
 rtl/game_timer_pkg.sv | 14 +
 rtl/tenths_to_bcd.sv | 25 ++
 rtl/round_timer.sv | 139 +++++++++++++
 tb/tb_round_timer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// Shared types and constants for the round countdown timer.
package game_timer_pkg;

    localparam int TENTHS_W   = 10;
    localparam int MAX_TENTHS = 999;

    typedef enum logic [1:0] {
        IDLE,
        RUNNING,
        PAUSED,
        EXPIRED
    } timer_state_t;

endpackage

// File: rtl/tenths_to_bcd.sv
// Combinational binary-to-BCD conversion (double-dabble) of a 0..999 tenths count.
module tenths_to_bcd
    import game_timer_pkg::*;
(
    input  logic [TENTHS_W-1:0] i_bin,
    output logic [11:0]         o_bcd
);

    logic [TENTHS_W+11:0] w_shift;

    // NOTE: always_comb assigns every output first, so no path can leave a latch.
    always_comb begin
        w_shift = {12'd0, i_bin};
        for (int i = 0; i < TENTHS_W; i++) begin
            for (int d = 0; d < 3; d++) begin
                if (w_shift[TENTHS_W + 4*d +: 4] >= 4'd5) begin
                    w_shift[TENTHS_W + 4*d +: 4] = w_shift[TENTHS_W + 4*d +: 4] + 4'd3;
                end
            end
            w_shift = w_shift << 1;
        end
        o_bcd = w_shift[TENTHS_W +: 12];
    end

endmodule

// File: rtl/round_timer.sv
// Per-round countdown driven by the 10 Hz tenths count: start, pause, bonus add,
// expiry pulse, low-time warning and registered BCD digits for the HUD.
module round_timer
    import game_timer_pkg::*;
#(
    parameter int ROUND_SECONDS = 60,
    parameter int BONUS_SECONDS = 5,
    parameter int WARN_TENTHS   = 100
)(
    input  logic                clk,
    input  logic                reset,
    input  logic [19:0]         clk_10,
    input  logic                start,
    input  logic                pause,
    input  logic                add_time,
    output logic [TENTHS_W-1:0] remaining_tenths,
    output logic [3:0]          sec_tens,
    output logic [3:0]          sec_ones,
    output logic [3:0]          tenths,
    output logic                running,
    output logic                expired,
    output logic                warning,
    output logic                time_up
);

    localparam logic [TENTHS_W-1:0] LOAD_TENTHS  = TENTHS_W'(ROUND_SECONDS * 10);
    localparam logic [TENTHS_W:0]   BONUS_TENTHS = (TENTHS_W+1)'(BONUS_SECONDS * 10);
    localparam logic [TENTHS_W:0]   SAT_TENTHS   = (TENTHS_W+1)'(MAX_TENTHS);
    localparam logic [TENTHS_W-1:0] WARN_LIMIT   = TENTHS_W'(WARN_TENTHS);
    localparam logic [11:0]         RESET_BCD    = {4'(ROUND_SECONDS / 10), 4'(ROUND_SECONDS % 10), 4'd0};

    timer_state_t        r_state;
    timer_state_t        w_state_next;
    logic [19:0]         r_prev_count;
    logic [TENTHS_W-1:0] r_remaining;
    logic [TENTHS_W-1:0] w_rem_next;
    logic [TENTHS_W:0]   w_sum;
    logic [TENTHS_W-1:0] w_sat;
    logic                w_tick;
    logic                w_time_up_next;
    logic [11:0]         w_bcd;
    logic [11:0]         r_bcd;
    logic                r_running;
    logic                r_expired;
    logic                r_warning;
    logic                r_time_up;

    // A return to 0 is a wrap or a system_clock reset, never a real tenth elapsing.
    assign w_tick = (clk_10 != r_prev_count) && (clk_10 != 20'd0);

    always_comb begin
        w_state_next   = r_state;
        w_rem_next     = r_remaining;
        w_time_up_next = 1'b0;
        w_sum          = {1'b0, r_remaining} + (add_time ? BONUS_TENTHS : '0);
        w_sat          = (w_sum > SAT_TENTHS) ? TENTHS_W'(MAX_TENTHS) : w_sum[TENTHS_W-1:0];

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_rem_next   = LOAD_TENTHS;
                    w_state_next = RUNNING;
                end
            end
            RUNNING: begin
                if (start) begin
                    w_rem_next = LOAD_TENTHS;
                end else begin
                    // The bonus is added before the tick, so a coincident add rescues the last tenth.
                    w_rem_next = w_sat - TENTHS_W'(w_tick);
                    if (w_tick && (w_rem_next == '0)) begin
                        w_state_next   = EXPIRED;
                        w_time_up_next = 1'b1;
                    end else if (pause) begin
                        w_state_next = PAUSED;
                    end
                end
            end
            PAUSED: begin
                if (start) begin
                    w_rem_next   = LOAD_TENTHS;
                    w_state_next = RUNNING;
                end else begin
                    w_rem_next = w_sat;
                    if (!pause) begin
                        w_state_next = RUNNING;
                    end
                end
            end
            EXPIRED: begin
                if (start) begin
                    w_rem_next   = LOAD_TENTHS;
                    w_state_next = RUNNING;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    tenths_to_bcd u_bcd (
        .i_bin (r_remaining),
        .o_bcd (w_bcd)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_prev_count <= '0;
            r_remaining  <= LOAD_TENTHS;
            r_bcd        <= RESET_BCD;
            r_running    <= 1'b0;
            r_expired    <= 1'b0;
            r_warning    <= 1'b0;
            r_time_up    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_prev_count <= clk_10;
            r_remaining  <= w_rem_next;
            r_bcd        <= w_bcd;
            r_running    <= (w_state_next == RUNNING);
            r_expired    <= (w_state_next == EXPIRED);
            r_warning    <= (w_state_next == RUNNING) && (w_rem_next <= WARN_LIMIT);
            r_time_up    <= w_time_up_next;
        end
    end

    assign remaining_tenths = r_remaining;
    assign sec_tens         = r_bcd[11:8];
    assign sec_ones         = r_bcd[7:4];
    assign tenths           = r_bcd[3:0];
    assign running          = r_running;
    assign expired          = r_expired;
    assign warning          = r_warning;
    assign time_up          = r_time_up;

endmodule

// File: tb/tb_round_timer.sv
// Self-checking bench for round_timer: a reference model pushes expected outputs per
// driven cycle, a monitor pops and compares them, and scenario tasks add targeted checks.
module tb_round_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] clk_10;
    logic        start;
    logic        pause;
    logic        add_time;
    logic [9:0]  remaining_tenths;
    logic [3:0]  sec_tens;
    logic [3:0]  sec_ones;
    logic [3:0]  tenths;
    logic        running;
    logic        expired;
    logic        warning;
    logic        time_up;

    round_timer dut (
        .clk              (clk),
        .reset            (reset),
        .clk_10           (clk_10),
        .start            (start),
        .pause            (pause),
        .add_time         (add_time),
        .remaining_tenths (remaining_tenths),
        .sec_tens         (sec_tens),
        .sec_ones         (sec_ones),
        .tenths           (tenths),
        .running          (running),
        .expired          (expired),
        .warning          (warning),
        .time_up          (time_up)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic [9:0] rem;
        logic       running;
        logic       expired;
        logic       time_up;
        logic       warning;
        logic [9:0] dig_rem;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;

    // Reference model: 0 IDLE, 1 RUNNING, 2 PAUSED, 3 EXPIRED
    int          m_st;
    int          m_rem;
    logic [19:0] m_prev;
    logic [19:0] c10_v;
    int          tu_seen;

    function automatic logic [11:0] bcd_of(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic model_reset();
        m_st   = 0;
        m_rem  = 600;
        m_prev = '0;
        sb_q.delete();
    endtask

    // One clock cycle of stimulus; the model's prediction goes to the scoreboard.
    task automatic cycle(input logic [19:0] c10, input logic s, input logic p, input logic a);
        exp_t e;
        bit   tick;
        int   sum;
        @(negedge clk);
        clk_10   = c10;
        start    = s;
        pause    = p;
        add_time = a;
        e.dig_rem = 10'(m_rem);
        e.time_up = 1'b0;
        tick   = (c10 != m_prev) && (c10 != 20'd0);
        m_prev = c10;
        sum = m_rem + (a ? 50 : 0);
        if (sum > 999) sum = 999;
        case (m_st)
            0: if (s) begin m_rem = 600; m_st = 1; end
            1: begin
                if (s) m_rem = 600;
                else begin
                    m_rem = sum - (tick ? 1 : 0);
                    if (tick && m_rem == 0) begin m_st = 3; e.time_up = 1'b1; end
                    else if (p) m_st = 2;
                end
            end
            2: begin
                if (s) begin m_rem = 600; m_st = 1; end
                else begin
                    m_rem = sum;
                    if (!p) m_st = 1;
                end
            end
            default: if (s) begin m_rem = 600; m_st = 1; end
        endcase
        e.rem     = 10'(m_rem);
        e.running = (m_st == 1);
        e.expired = (m_st == 3);
        e.warning = (m_st == 1) && (m_rem <= 100);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (time_up) tu_seen++;
    endtask

    task automatic inc_ticks(input int n, input int gap, input logic p);
        for (int i = 0; i < n; i++) begin
            c10_v = c10_v + 20'd1;
            cycle(c10_v, 1'b0, p, 1'b0);
            for (int g = 1; g < gap; g++) cycle(c10_v, 1'b0, p, 1'b0);
        end
    endtask

    always @(posedge clk) begin : monitor
        exp_t e;
        #2;
        if (!reset && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            if (remaining_tenths !== e.rem) begin
                n_errors++;
                $display("FAIL sb_remaining t=%0t got %0d expected %0d", $time, remaining_tenths, e.rem);
            end
            n_checks++;
            if ({running, expired, time_up, warning} !== {e.running, e.expired, e.time_up, e.warning}) begin
                n_errors++;
                $display("FAIL sb_flags t=%0t got run/exp/tu/warn=%b expected %b", $time,
                         {running, expired, time_up, warning}, {e.running, e.expired, e.time_up, e.warning});
            end
            n_checks++;
            if ({sec_tens, sec_ones, tenths} !== bcd_of(int'(e.dig_rem))) begin
                n_errors++;
                $display("FAIL sb_digits t=%0t got %h expected %h", $time,
                         {sec_tens, sec_ones, tenths}, bcd_of(int'(e.dig_rem)));
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1; clk_10 = '0; start = 0; pause = 0; add_time = 0;
        c10_v = '0; tu_seen = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (remaining_tenths !== 10'd600 || {sec_tens, sec_ones, tenths} !== 12'h600) begin
            n_errors++;
            $display("FAIL reset_values got rem=%0d bcd=%h expected 600/600", remaining_tenths, {sec_tens, sec_ones, tenths});
        end
        n_checks++;
        if ({running, expired, warning, time_up} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags got %b expected 0000", {running, expired, warning, time_up});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_countdown();
        cycle(c10_v, 1'b1, 1'b0, 1'b0);
        inc_ticks(4, 1000, 1'b0);
        c10_v = c10_v + 20'd1;
        cycle(c10_v, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (remaining_tenths !== 10'd595 || running !== 1'b1 || {sec_tens, sec_ones, tenths} !== 12'h596) begin
            n_errors++;
            $display("FAIL countdown_595 got rem=%0d run=%b bcd=%h expected 595/1/596",
                     remaining_tenths, running, {sec_tens, sec_ones, tenths});
        end
        cycle(c10_v, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if ({sec_tens, sec_ones, tenths} !== 12'h595) begin
            n_errors++;
            $display("FAIL digits_latency got %h expected 595", {sec_tens, sec_ones, tenths});
        end
    endtask

    task automatic test_expiry();
        int n;
        n = 0;
        cycle(c10_v, 1'b1, 1'b0, 1'b0);
        tu_seen = 0;
        while (expired !== 1'b1 && n < 700) begin
            inc_ticks(1, 3, 1'b0);
            n++;
        end
        n_checks++;
        if (n !== 600) begin
            n_errors++;
            $display("FAIL expiry_ticks got %0d expected 600", n);
        end
        n_checks++;
        if (tu_seen !== 1) begin
            n_errors++;
            $display("FAIL time_up_pulses got %0d expected 1", tu_seen);
        end
        cycle(c10_v, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (remaining_tenths !== 10'd0 || {running, expired, warning} !== 3'b010) begin
            n_errors++;
            $display("FAIL expired_hold got rem=%0d run/exp/warn=%b expected 0/010",
                     remaining_tenths, {running, expired, warning});
        end
    endtask

    task automatic test_pause();
        logic [9:0] rem0;
        cycle(c10_v, 1'b1, 1'b0, 1'b0);
        inc_ticks(3, 2, 1'b0);
        cycle(c10_v, 1'b0, 1'b1, 1'b0);
        rem0 = remaining_tenths;
        inc_ticks(20, 2, 1'b1);
        n_checks++;
        if (remaining_tenths !== rem0 || running !== 1'b0) begin
            n_errors++;
            $display("FAIL pause_hold got rem=%0d run=%b expected %0d/0", remaining_tenths, running, rem0);
        end
        repeat (3) cycle(c10_v, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (remaining_tenths !== rem0 || running !== 1'b1) begin
            n_errors++;
            $display("FAIL pause_release got rem=%0d run=%b expected %0d/1", remaining_tenths, running, rem0);
        end
        inc_ticks(1, 1, 1'b0);
        n_checks++;
        if (remaining_tenths !== rem0 - 10'd1) begin
            n_errors++;
            $display("FAIL resume_tick got %0d expected %0d", remaining_tenths, rem0 - 10'd1);
        end
    endtask

    task automatic test_add_time();
        cycle(c10_v, 1'b1, 1'b0, 1'b0);
        repeat (8) cycle(c10_v, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (remaining_tenths !== 10'd999) begin
            n_errors++;
            $display("FAIL add_saturate got %0d expected 999", remaining_tenths);
        end
        inc_ticks(19, 1, 1'b0);
        cycle(c10_v, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (remaining_tenths !== 10'd999) begin
            n_errors++;
            $display("FAIL add_at_980 got %0d expected 999", remaining_tenths);
        end
        inc_ticks(998, 1, 1'b0);
        n_checks++;
        if (remaining_tenths !== 10'd1) begin
            n_errors++;
            $display("FAIL countdown_to_1 got %0d expected 1", remaining_tenths);
        end
        tu_seen = 0;
        c10_v = c10_v + 20'd1;
        cycle(c10_v, 1'b0, 1'b0, 1'b1);
        cycle(c10_v, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (remaining_tenths !== 10'd50 || tu_seen !== 0 || {running, expired} !== 2'b10) begin
            n_errors++;
            $display("FAIL add_beats_tick got rem=%0d tu=%0d run/exp=%b expected 50/0/10",
                     remaining_tenths, tu_seen, {running, expired});
        end
    endtask

    task automatic test_wrap();
        logic [9:0] rem_w;
        cycle(c10_v, 1'b1, 1'b0, 1'b0);
        c10_v = 20'd1000000;
        cycle(c10_v, 1'b0, 1'b0, 1'b0);
        c10_v = 20'd1000001;
        cycle(c10_v, 1'b0, 1'b0, 1'b0);
        rem_w = remaining_tenths;
        c10_v = 20'd0;
        repeat (4) cycle(c10_v, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (remaining_tenths !== rem_w || rem_w !== 10'd598) begin
            n_errors++;
            $display("FAIL wrap_no_tick got %0d expected %0d", remaining_tenths, 598);
        end
        inc_ticks(1, 2, 1'b0);
        n_checks++;
        if (remaining_tenths !== 10'd597) begin
            n_errors++;
            $display("FAIL after_wrap got %0d expected 597", remaining_tenths);
        end
    endtask

    task automatic test_reset_mid_round();
        cycle(c10_v, 1'b1, 1'b0, 1'b0);
        inc_ticks(477, 1, 1'b0);
        n_checks++;
        if (remaining_tenths !== 10'd123) begin
            n_errors++;
            $display("FAIL reach_123 got %0d expected 123", remaining_tenths);
        end
        #4;
        reset = 1'b1;
        #1;
        n_checks++;
        if (remaining_tenths !== 10'd600 || {sec_tens, sec_ones, tenths} !== 12'h600 ||
            {running, expired, warning, time_up} !== 4'b0000) begin
            n_errors++;
            $display("FAIL async_reset got rem=%0d bcd=%h flags=%b expected 600/600/0000",
                     remaining_tenths, {sec_tens, sec_ones, tenths}, {running, expired, warning, time_up});
        end
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        tu_seen = 0;
        repeat (3) cycle(c10_v, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (tu_seen !== 0 || running !== 1'b0 || remaining_tenths !== 10'd600) begin
            n_errors++;
            $display("FAIL idle_after_reset got tu=%0d run=%b rem=%0d expected 0/0/600",
                     tu_seen, running, remaining_tenths);
        end
    endtask

    task automatic test_start_in_expired();
        cycle(c10_v, 1'b1, 1'b0, 1'b0);
        inc_ticks(600, 1, 1'b0);
        n_checks++;
        if (expired !== 1'b1) begin
            n_errors++;
            $display("FAIL reach_expired got %b expected 1", expired);
        end
        cycle(c10_v, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (remaining_tenths !== 10'd600 || {running, expired} !== 2'b10) begin
            n_errors++;
            $display("FAIL restart_from_expired got rem=%0d run/exp=%b expected 600/10",
                     remaining_tenths, {running, expired});
        end
        cycle(c10_v, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #(400000 * 20);
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_countdown();
        test_expiry();
        test_pause();
        test_add_time();
        test_wrap();
        test_reset_mid_round();
        test_start_in_expired();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
